// File: rtl/serial_bus_master.sv
// Initiator for the single-wire serial memory bus: serialises one host request (ID, address,
// optional write data), then waits for the slave ack or read data, with a response timeout.
module serial_bus_master #(
  parameter int unsigned ADDRESS_WIDTH = 15,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ID_WIDTH      = 3,
  parameter int unsigned TIMEOUT       = 1023
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req,
  input  logic                     req_wr,
  input  logic [ID_WIDTH-1:0]      req_id,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     done,
  output logic                     timeout_err,
  output logic                     busy,
  output logic                     bus_util,
  output logic                     rd_wrt,
  inout  wire                      data_bus_serial,
  input  logic                     slave_busy
);

  localparam int unsigned TxW     = ID_WIDTH + ADDRESS_WIDTH + DATA_WIDTH;
  localparam int unsigned MaxW    = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
  localparam int unsigned BitCntW = $clog2(MaxW + 1);
  localparam int unsigned TmoW    = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StId, StAddr, StWdata, StWaitAck, StRstart, StRdata, StFinish
  } state_e;

  state_e                  state_q, state_d;
  logic                    wr_q, wr_d;
  logic [TxW-1:0]          tx_q, tx_d;
  logic [BitCntW-1:0]      bit_q, bit_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic [DATA_WIDTH-2:0]   rx_q, rx_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    drive_en;
  logic                    line_one;
  logic [DATA_WIDTH-1:0]   rx_full;

  // Undriven line is pulled low externally, so only a definite 1 counts.
  assign line_one = (data_bus_serial === 1'b1);
  assign rx_full  = {rx_q, line_one};

  assign data_bus_serial = drive_en ? tx_q[TxW-1] : 1'bz;
  assign rdata           = rdata_q;

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    tx_d        = tx_q;
    bit_d       = bit_q;
    tmo_d       = tmo_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    drive_en    = 1'b0;
    bus_util    = 1'b0;
    rd_wrt      = 1'b0;
    done        = 1'b0;
    timeout_err = 1'b0;
    busy        = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StId;
          wr_d    = req_wr;
          tx_d    = {req_id, req_addr, req_wdata};
          bit_d   = BitCntW'(ID_WIDTH - 1);
          err_d   = 1'b0;
        end
      end
      StId: begin
        bus_util = 1'b1;
        rd_wrt   = wr_q;
        drive_en = 1'b1;
        tx_d     = tx_q << 1;
        if (bit_q == '0) begin
          state_d = StAddr;
          bit_d   = BitCntW'(ADDRESS_WIDTH - 1);
        end else begin
          bit_d = bit_q - BitCntW'(1);
        end
      end
      StAddr: begin
        bus_util = 1'b1;
        rd_wrt   = wr_q;
        drive_en = 1'b1;
        tx_d     = tx_q << 1;
        if (bit_q == '0) begin
          tmo_d = '0;
          if (wr_q) begin
            state_d = StWdata;
            bit_d   = BitCntW'(DATA_WIDTH - 1);
          end else begin
            state_d = StRstart;
          end
        end else begin
          bit_d = bit_q - BitCntW'(1);
        end
      end
      StWdata: begin
        bus_util = 1'b1;
        rd_wrt   = wr_q;
        drive_en = 1'b1;
        tx_d     = tx_q << 1;
        if (bit_q == '0) begin
          state_d = StWaitAck;
          tmo_d   = '0;
        end else begin
          bit_d = bit_q - BitCntW'(1);
        end
      end
      StWaitAck: begin
        bus_util = 1'b1;
        rd_wrt   = wr_q;
        // tmo_q is zero only on the blanking cycle, where slave_busy is not yet valid.
        if (tmo_q != '0 && !slave_busy) begin
          state_d = StFinish;
        end else if (tmo_q == TmoLast) begin
          state_d = StFinish;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StRstart: begin
        bus_util = 1'b1;
        rd_wrt   = wr_q;
        if (line_one) begin
          state_d = StRdata;
          bit_d   = BitCntW'(DATA_WIDTH - 1);
        end else if (tmo_q == TmoLast) begin
          state_d = StFinish;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StRdata: begin
        bus_util = 1'b1;
        rd_wrt   = wr_q;
        rx_d     = rx_full[DATA_WIDTH-2:0];
        if (bit_q == '0) begin
          rdata_d = rx_full;
          state_d = StFinish;
        end else begin
          bit_d = bit_q - BitCntW'(1);
        end
      end
      StFinish: begin
        done        = 1'b1;
        timeout_err = err_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      tx_q    <= '0;
      bit_q   <= '0;
      tmo_q   <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      tx_q    <= tx_d;
      bit_q   <= bit_d;
      tmo_q   <= tmo_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_serial_bus_master.sv
// Self-checking bench for serial_bus_master: a timeline model of each transaction plus a
// simple slave that acks writes and returns read data on the shared line.
module tb_serial_bus_master;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic        req_wr = 1'b0;
  logic [2:0]  req_id = '0;
  logic [14:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic [7:0]  rdata;
  logic        done, timeout_err, busy, bus_util, rd_wrt;
  wire         data_bus_serial;
  logic        slave_busy = 1'b0;
  logic        s_en = 1'b0;
  logic        s_bit = 1'b0;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic [7:0]  rdata_m = '0;

  assign data_bus_serial = s_en ? s_bit : 1'bz;

  serial_bus_master #(
    .ADDRESS_WIDTH(15),
    .DATA_WIDTH   (8),
    .ID_WIDTH     (3),
    .TIMEOUT      (TMO)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req            (req),
    .req_wr         (req_wr),
    .req_id         (req_id),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rdata          (rdata),
    .done           (done),
    .timeout_err    (timeout_err),
    .busy           (busy),
    .bus_util       (bus_util),
    .rd_wrt         (rd_wrt),
    .data_bus_serial(data_bus_serial),
    .slave_busy     (slave_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Caller is 1+ time units after a rising edge with the DUT idle. Returns one cycle into IDLE.
  task automatic run_txn(input bit wr, input logic [2:0] id, input logic [14:0] addr,
                         input logic [7:0] wd, input int bsy, input int sdel,
                         input logic [7:0] rbyte, input bit hold, input string name);
    logic [25:0] stream;
    logic [4:0]  exp_o, got_o;
    int          ntx, wlen, ack, n, k;
    bit          err;
    stream = {id, addr, wd};
    ntx    = wr ? 26 : 18;
    err    = 1'b0;
    if (wr) begin
      ack = (bsy + 1 < 2) ? 2 : bsy + 1;
      if (ack <= TMO) wlen = ack;
      else begin wlen = TMO; err = 1'b1; end
    end else begin
      if (sdel + 1 <= TMO) wlen = sdel + 1 + 8;
      else begin wlen = TMO; err = 1'b1; end
    end
    n = ntx + wlen;
    req = 1'b1; req_wr = wr; req_id = id; req_addr = addr; req_wdata = wd;
    for (int c = 1; c <= n + 2; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        // Scramble request fields: the DUT must be working from its latched copy.
        req = hold;
        req_wr = 1'($urandom_range(0, 1));
        req_id = 3'($urandom);
        req_addr = 15'($urandom);
        req_wdata = 8'($urandom);
      end
      k = c - ntx;
      s_en = 1'b0; s_bit = 1'b0; slave_busy = 1'b0;
      if (wr) slave_busy = (k >= 1 && k <= bsy);
      else if (!err && k == sdel + 1) begin s_en = 1'b1; s_bit = 1'b1; end
      else if (!err && k > sdel + 1 && k <= sdel + 9) begin
        s_en = 1'b1; s_bit = rbyte[7 - (k - sdel - 2)];
      end
      #1;
      if (c == n + 1 && !wr && !err) rdata_m = rbyte;
      if (c <= n)          exp_o = {1'b1, wr, 1'b1, 1'b0, 1'b0};
      else if (c == n + 1) exp_o = {1'b0, 1'b0, 1'b1, 1'b1, err};
      else                 exp_o = 5'b0;
      got_o = {bus_util, rd_wrt, busy, done, timeout_err};
      checks++;
      if (got_o !== exp_o) begin
        errors++;
        $display("FAIL %s ctl cycle %0d: util/rdwr/busy/done/err got %b required %b",
                 name, c, got_o, exp_o);
      end
      checks++;
      if (rdata !== rdata_m) begin
        errors++;
        $display("FAIL %s rdata cycle %0d: got %h required %h", name, c, rdata, rdata_m);
      end
      if (c <= ntx) begin
        checks++;
        if (data_bus_serial !== stream[26 - c]) begin
          errors++;
          $display("FAIL %s serial bit %0d: got %b required %b", name, c, data_bus_serial,
                   stream[26 - c]);
        end
      end else if (!s_en) begin
        checks++;
        if (data_bus_serial === 1'b1) begin
          errors++;
          $display("FAIL %s release cycle %0d: got %b required released", name, c,
                   data_bus_serial);
        end
      end
    end
    s_en = 1'b0; s_bit = 1'b0; slave_busy = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus_util, rd_wrt, busy, done, timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset ctl: got %b required 00000",
               {bus_util, rd_wrt, busy, done, timeout_err});
    end
    checks++;
    if (rdata !== 8'h00) begin
      errors++; $display("FAIL reset rdata: got %h required 00", rdata);
    end
    checks++;
    if (data_bus_serial === 1'b1) begin
      errors++; $display("FAIL reset line: got %b required released", data_bus_serial);
    end
    #10 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    run_txn(1'b1, 3'd3, 15'h0123, 8'hA5, 4, 0, 8'h00, 1'b0, "write");
  endtask

  task automatic test_read();
    run_txn(1'b0, 3'd5, 15'h7FFF, 8'h00, 0, 6, 8'h3C, 1'b0, "read");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 3'd2, 15'h0456, 8'h00, 0, 1000, 8'hFF, 1'b0, "read_timeout");
  endtask

  task automatic test_reset_mid();
    int d0;
    req = 1'b1; req_wr = 1'b1; req_id = 3'd7; req_addr = 15'h7FFF; req_wdata = 8'hFF;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus_util !== 1'b1 || data_bus_serial !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset pre: util %b line %b required 1 1", bus_util, data_bus_serial);
    end
    d0 = done_cnt;
    #2 rstn = 1'b0;
    #1;
    rdata_m = 8'h00;
    checks++;
    if ({bus_util, rd_wrt, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset async: util/rdwr/busy/done got %b required 0000",
               {bus_util, rd_wrt, busy, done});
    end
    checks++;
    if (data_bus_serial === 1'b1) begin
      errors++; $display("FAIL mid_reset line: got %b required released", data_bus_serial);
    end
    checks++;
    if (rdata !== 8'h00) begin
      errors++; $display("FAIL mid_reset rdata: got %h required 00", rdata);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset after: done pulses %0d busy %b required 0 0", done_cnt - d0,
               busy);
    end
    run_txn(1'b1, 3'd1, 15'h2AAA, 8'h5A, 3, 0, 8'h00, 1'b0, "post_reset_write");
  endtask

  task automatic test_back_to_back();
    int d0;
    logic [7:0] rb;
    d0 = done_cnt;
    rb = 8'($urandom);
    run_txn(1'b1, 3'd4, 15'h1234, 8'h11, 2, 0, 8'h00, 1'b1, "b2b_write");
    run_txn(1'b0, 3'd6, 15'h0F0F, 8'h00, 0, 3, rb, 1'b0, "b2b_read");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - d0 !== 2) begin
      errors++; $display("FAIL b2b done count: got %0d required 2", done_cnt - d0);
    end
  endtask

  task automatic test_blanking();
    run_txn(1'b1, 3'd0, 15'h4001, 8'h3C, 0, 0, 8'h00, 1'b0, "blanking");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom), 15'($urandom), 8'($urandom),
              int'($urandom_range(0, 24)), int'($urandom_range(0, 22)), 8'($urandom),
              1'($urandom_range(0, 1)), "random");
    end
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_blanking();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
